// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
// The state encoding is fixed so that the FSM values match the datapath documentation.
package nibble_serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // The nibble counter needs at least one bit, even when there is only a single nibble.
   function automatic int cnt_width(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/nibble_serial_adder_rca4.sv
// 4-bit ripple-carry adder slice, used once per clock by the serial adder.
module nibble_serial_adder_rca4
   import nibble_serial_adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] i_a,
   input  logic [NIBBLE_W-1:0] i_b,
   input  logic                i_cin,
   output logic [NIBBLE_W-1:0] o_sum,
   output logic                o_cout
);

   logic [NIBBLE_W:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
      assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
   end

   assign o_cout = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder/subtractor that processes one nibble per clock through a single RCA4,
// with valid/ready handshakes on both the operand and the result side.
//
// state | meaning
// IDLE  | waiting for operands; in_ready high
// RUN   | one nibble added per clock, low nibble first
// DONE  | result held on the outputs until out_ready
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int CNT_W   = cnt_width(NIBBLES);

   if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a non-zero multiple of 4");
   end

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_c;
   logic               r_msb_a;
   logic               r_msb_b;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;
   logic               r_ovf;

   logic               w_load;
   logic               w_step;
   logic               w_last;
   logic [NIBBLE_W-1:0] w_rca_sum;
   logic               w_rca_cout;
   logic [WIDTH-1:0]   w_acc_next;

   nibble_serial_adder_rca4 u_rca4 (
      .i_a    (r_a[NIBBLE_W-1:0]),
      .i_b    (r_b[NIBBLE_W-1:0]),
      .i_cin  (r_c),
      .o_sum  (w_rca_sum),
      .o_cout (w_rca_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_load      = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_step = 1'b1;
            if (r_cnt == CNT_W'(NIBBLES - 1)) begin
               w_last      = 1'b1;
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Partial sums are shifted in from the top, so after the last nibble the
   // accumulator plus the current RCA4 sum form the complete result.
   if (WIDTH > NIBBLE_W) begin : g_acc
      logic [WIDTH-NIBBLE_W-1:0] r_acc;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)      r_acc <= '0;
         else if (w_step) r_acc <= w_acc_next[WIDTH-1:NIBBLE_W];
      end

      assign w_acc_next = {w_rca_sum, r_acc};
   end else begin : g_acc_single
      assign w_acc_next = w_rca_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_c     <= 1'b0;
         r_msb_a <= 1'b0;
         r_msb_b <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_load) begin
         // Subtraction is A + ~B + 1, so the borrow-in inverts into the carry-in.
         r_a     <= a;
         r_b     <= op_sub ? ~b : b;
         r_c     <= cin ^ op_sub;
         r_msb_a <= a[WIDTH-1];
         r_msb_b <= b[WIDTH-1] ^ op_sub;
         r_cnt   <= '0;
      end else if (w_step) begin
         r_a   <= r_a >> NIBBLE_W;
         r_b   <= r_b >> NIBBLE_W;
         r_c   <= w_rca_cout;
         r_cnt <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_sum  <= w_acc_next;
            r_cout <= w_rca_cout;
            r_ovf  <= (r_msb_a == r_msb_b) && (w_acc_next[WIDTH-1] != r_msb_a);
         end
      end
   end

   assign sum      = r_sum;
   assign cout     = r_cout;
   assign overflow = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16.
`timescale 1ns/1ps
module tb_nibble_serial_adder;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             op_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   int checks = 0;
   int errors = 0;

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer one operation, wait for its result and check latency and value.
   task automatic run_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                         input logic op_cin, input logic op_s, input logic [15:0] exp_sum,
                         input logic exp_cout, input logic exp_ovf);
      int lat;
      in_valid = 1'b1;
      a        = op_a;
      b        = op_b;
      cin      = op_cin;
      op_sub   = op_s;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a        = 16'hDEAD;
      b        = 16'hBEEF;
      check({tag, "_busy"}, 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd4);
      check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
      check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
      check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
   endtask

   task automatic take_result(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_ack_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_ack_ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int seen;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      op_sub    = 1'b0;
      out_ready = 1'b0;
      #12;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Case 1 plus backpressure with a pending, ignored request.
      run_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      in_valid = 1'b1;
      a        = 16'h1111;
      b        = 16'h2222;
      cin      = 1'b0;
      op_sub   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_sum", 32'(sum), 32'h5555);
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_rel_ready", 32'(in_ready), 32'd1);
      check("bp_rel_valid", 32'(out_valid), 32'd0);
      check("bp_rel_sum", 32'(sum), 32'h5555);
      run_op("pending", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
      take_result("pending");

      run_op("carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      take_result("carry");
      run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      take_result("ovf_add");
      run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      take_result("sub_neg");
      run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      take_result("sub_ovf");
      run_op("add_cin", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
      take_result("add_cin");
      run_op("sub_bin", 16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFE, 1'b1, 1'b0);
      take_result("sub_bin");

      // Reset asserted during the second RUN cycle.
      in_valid = 1'b1;
      a        = 16'h1234;
      b        = 16'h0001;
      cin      = 1'b0;
      op_sub   = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_sum", 32'(sum), 32'd0);
      check("mid_rst_cout", 32'(cout), 32'd0);
      check("mid_rst_ovf", 32'(overflow), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("post_rst_no_valid", 32'(seen), 32'd0);
      run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
      take_result("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
